// File: rtl/pipe_stall_flush_ctrl_if.sv
// Pipeline control bundle: stall/redirect requests in, stall/bubble/flush vectors,
// fetch redirect and stall statistics out.
interface pipe_stall_flush_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 32
);
  logic [NSTAGE-1:0]           stall_req_i;
  logic [NSTAGE-1:0]           flush_req_i;
  logic [NSTAGE-1:0][PC_W-1:0] redirect_pc_i;
  logic                        redirect_ready_i;
  logic [NSTAGE-1:0]           stall_o;
  logic [NSTAGE-1:0]           bubble_o;
  logic [NSTAGE-1:0]           flush_o;
  logic                        redirect_valid_o;
  logic [PC_W-1:0]             redirect_pc_o;
  logic                        stall_timeout_o;
  logic [CNT_W-1:0]            stall_cycles_o;

  modport master (
    output stall_req_i, flush_req_i, redirect_pc_i, redirect_ready_i,
    input  stall_o, bubble_o, flush_o, redirect_valid_o, redirect_pc_o,
           stall_timeout_o, stall_cycles_o
  );

  modport slave (
    input  stall_req_i, flush_req_i, redirect_pc_i, redirect_ready_i,
    output stall_o, bubble_o, flush_o, redirect_valid_o, redirect_pc_o,
           stall_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_stall_flush_ctrl.sv
// Resolves stall/redirect requests into hold/bubble/flush vectors, runs the fetch
// redirect handshake (1-cycle latency, held until ready) and a stall watchdog/counter.
module pipe_stall_flush_ctrl #(
  parameter int NSTAGE    = 5,
  parameter int PC_W      = 64,
  parameter int STALL_MAX = 255,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_stall_flush_ctrl_if.slave bus
);
  localparam int RUN_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_MAX);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t            state_q, state_d;
  logic [NSTAGE-1:0] smask, fmask;
  logic [NSTAGE-1:0] stall_v, bubble_v, flush_v;
  logic              sacc, facc, accept;
  logic [PC_W-1:0]   sel_pc, pc_q;
  logic [RUN_W-1:0]  run_q;
  logic [CNT_W-1:0]  cyc_q;

  always_comb begin
    smask    = '0;
    fmask    = '0;
    sacc     = 1'b0;
    facc     = 1'b0;
    sel_pc   = bus.redirect_pc_i[0];
    bubble_v = '0;
    flush_v  = '0;
    state_d  = state_q;

    // smask[j]: some stage at or above j stalls; fmask[j]: j is at or below the top flush
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      sacc     = sacc | bus.stall_req_i[j];
      smask[j] = sacc;
    end
    for (int j = NSTAGE - 1; j >= 1; j--) begin
      facc     = facc | bus.flush_req_i[j];
      fmask[j] = facc;
    end
    fmask[0] = facc;
    accept   = facc && !(|(bus.stall_req_i & ~fmask));

    for (int j = 1; j < NSTAGE; j++) begin
      if (bus.flush_req_i[j]) sel_pc = bus.redirect_pc_i[j];
    end

    stall_v = smask;
    for (int j = 1; j < NSTAGE; j++) begin
      bubble_v[j] = smask[j-1] & ~smask[j];
    end

    if (accept) begin
      flush_v    = fmask;
      flush_v[0] = 1'b0;
      stall_v    = stall_v & ~flush_v;
      bubble_v   = bubble_v & ~flush_v;
    end

    // Fetch holds while the redirect is outstanding
    if (state_q == REDIR) stall_v[0] = 1'b1;

    case (state_q)
      IDLE:    if (accept) state_d = REDIR;
      REDIR:   if (!accept && bus.redirect_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rst) begin
      stall_v  = '0;
      bubble_v = '0;
      flush_v  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      run_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) pc_q <= sel_pc;
      if (|stall_v) begin
        if (run_q != RUN_MAX) run_q <= run_q + RUN_W'(1);
        cyc_q <= cyc_q + CNT_W'(1);
      end else begin
        run_q <= '0;
      end
    end
  end

  assign bus.stall_o          = stall_v;
  assign bus.bubble_o         = bubble_v;
  assign bus.flush_o          = flush_v;
  assign bus.redirect_valid_o = (state_q == REDIR) && !rst;
  assign bus.redirect_pc_o    = pc_q;
  assign bus.stall_timeout_o  = (run_q == RUN_MAX);
  assign bus.stall_cycles_o   = cyc_q;
endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Randomized bench for pipe_stall_flush_ctrl: driver pushes model expectations per cycle,
// an independent monitor pops and compares them against the DUT outputs.
module tb_pipe_stall_flush_ctrl;
  localparam int N     = 5;
  localparam int PCW   = 64;
  localparam int CW    = 8;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_flush_ctrl_if #(.NSTAGE(N), .PC_W(PCW), .CNT_W(CW)) bus ();

  pipe_stall_flush_ctrl #(.NSTAGE(N), .PC_W(PCW), .STALL_MAX(SMAX), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0]   stall, bubble, flush;
    logic           in_rst;
    logic           vld;
    logic [PCW-1:0] pc;
    logic           to;
    logic [CW-1:0]  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state as visible during the current cycle
  bit             model_ok = 0;
  bit             m_pend;
  logic [PCW-1:0] m_pc;
  int             m_run;
  int             m_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] sr, input logic [N-1:0] fr,
                      input logic [N-1:0][PCW-1:0] pcs, input logic rdy, input logic r);
    exp_t e;
    int   s, f;
    bit   acc, any;
    @(posedge clk);
    #1;
    bus.stall_req_i      = sr;
    bus.flush_req_i      = fr;
    bus.redirect_pc_i    = pcs;
    bus.redirect_ready_i = rdy;
    rst                  = r;

    s = -1;
    for (int i = 0; i < N; i++) if (sr[i]) s = i;
    f = 0;
    for (int i = 1; i < N; i++) if (fr[i]) f = i;
    acc = (f > 0);
    for (int i = f + 1; i < N; i++) if (sr[i]) acc = 0;

    e.stall = '0; e.bubble = '0; e.flush = '0;
    for (int j = 0; j < N; j++) e.stall[j] = (j <= s);
    if (s >= 0 && s + 1 < N) e.bubble[s+1] = 1'b1;
    if (acc) begin
      for (int j = 1; j <= f; j++) begin
        e.flush[j] = 1'b1; e.stall[j] = 1'b0; e.bubble[j] = 1'b0;
      end
    end
    if (m_pend) e.stall[0] = 1'b1;
    if (r) begin
      e.stall = '0; e.bubble = '0; e.flush = '0;
    end
    e.in_rst = r;
    e.vld    = m_pend && !r;
    e.pc     = m_pc;
    e.to     = (m_run == SMAX);
    e.cyc    = CW'(m_cyc);
    if (model_ok) exp_q.push_back(e);

    any = (e.stall != '0);
    if (r) begin
      m_pend = 0; m_pc = '0; m_run = 0; m_cyc = 0; model_ok = 1;
    end else begin
      if (acc) begin
        m_pc = pcs[f]; m_pend = 1;
      end else if (m_pend && rdy) begin
        m_pend = 0;
      end
      m_run = any ? ((m_run + 1 > SMAX) ? SMAX : m_run + 1) : 0;
      if (any) m_cyc = (m_cyc + 1) % (1 << CW);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare at mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_o", 64'(bus.stall_o), 64'(e.stall));
      check("bubble_o", 64'(bus.bubble_o), 64'(e.bubble));
      check("flush_o", 64'(bus.flush_o), 64'(e.flush));
      if (!e.in_rst) check("redirect_valid_o", 64'(bus.redirect_valid_o), 64'(e.vld));
      if (e.vld) check("redirect_pc_o", bus.redirect_pc_o, e.pc);
      check("stall_timeout_o", 64'(bus.stall_timeout_o), 64'(e.to));
      check("stall_cycles_o", 64'(bus.stall_cycles_o), 64'(e.cyc));
    end
  end

  logic [N-1:0][PCW-1:0] pz, pa, pr;

  initial begin
    rst = 1'b1;
    bus.stall_req_i = '0; bus.flush_req_i = '0;
    bus.redirect_pc_i = '0; bus.redirect_ready_i = 1'b0;
    pz = '0;
    step('0, '0, pz, 0, 1);
    step('0, '0, pz, 0, 1);
    step('0, '0, pz, 0, 0);

    step(5'b00100, '0, pz, 0, 0);
    step(5'b10001, '0, pz, 0, 0);
    step('0, '0, pz, 0, 0);

    pa = '0; pa[3] = 64'h0000_0000_8000_0040;
    step('0, 5'b01000, pa, 0, 0);
    repeat (3) step('0, '0, pz, 0, 0);
    step('0, '0, pz, 1, 0);
    step('0, '0, pz, 0, 0);

    pa = '0; pa[2] = 64'h0000_0000_0000_1230;
    step(5'b10000, 5'b00100, pa, 0, 0);
    step('0, 5'b00100, pa, 1, 0);
    pa = '0; pa[4] = 64'hB000_0000_0000_00B0;
    step('0, 5'b10000, pa, 1, 0);
    step('0, '0, pz, 1, 0);
    step('0, '0, pz, 0, 0);

    repeat (6) step(5'b00100, '0, pz, 0, 0);
    step('0, '0, pz, 0, 0);
    step('0, '0, pz, 0, 0);

    pa = '0; pa[1] = 64'hDEAD_BEEF_0000_0010;
    step('0, 5'b00010, pa, 0, 0);
    repeat (9) step(5'b00001, '0, pz, 0, 0);
    step('0, '0, pz, 0, 1);
    step('0, '0, pz, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] sr, fr;
      sr = '0; fr = '0;
      for (int i = 0; i < N; i++) begin
        sr[i] = ($urandom_range(0, 5) == 0);
        fr[i] = ($urandom_range(0, 6) == 0);
        pr[i] = {$urandom, $urandom};
      end
      if ((c / 40) % 5 == 4) sr[$urandom_range(0, N-1)] = 1'b1;
      step(sr, fr, pr, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
